// File: rtl/mandelbrot_iter_ctrl_if.sv
// Bundle of the point-in, ALU and result-out signals of the Mandelbrot
// iteration controller. The slave view is the controller itself. The master
// view is whatever surrounds it: the point source, the combinational ALU and
// the pixel/colour stage.
interface mandelbrot_iter_ctrl_if #(
    parameter int WIDTH      = 8,
    parameter int ITER_WIDTH = 6
);
    // point input
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_cr;
    logic [WIDTH-1:0]      in_ci;
    logic [ITER_WIDTH-1:0] max_iter;
    // ALU operands (registered) and ALU results (combinational)
    logic [WIDTH-1:0]      alu_cr;
    logic [WIDTH-1:0]      alu_ci;
    logic [WIDTH-1:0]      alu_zr;
    logic [WIDTH-1:0]      alu_zi;
    logic [WIDTH-1:0]      alu_zr_next;
    logic [WIDTH-1:0]      alu_zi_next;
    logic                  alu_size;
    logic                  alu_overflow;
    // result output
    logic                  out_valid;
    logic                  out_ready;
    logic [ITER_WIDTH-1:0] out_iter;
    logic                  out_escaped;

    modport slave (
        input  in_valid, in_cr, in_ci, max_iter,
        input  alu_zr_next, alu_zi_next, alu_size, alu_overflow,
        input  out_ready,
        output in_ready, alu_cr, alu_ci, alu_zr, alu_zi,
        output out_valid, out_iter, out_escaped
    );

    modport master (
        output in_valid, in_cr, in_ci, max_iter,
        output alu_zr_next, alu_zi_next, alu_size, alu_overflow,
        output out_ready,
        input  in_ready, alu_cr, alu_ci, alu_zr, alu_zi,
        input  out_valid, out_iter, out_escaped
    );
endinterface

// File: rtl/mandelbrot_iter_ctrl.sv
// Mandelbrot iteration sequencer. It takes one point c at a time and drives
// the external single-step ALU from registered z and c. The ALU result is fed
// back into z once per cycle. The controller stops on escape (size or
// overflow) or when the count reaches the latched limit, then holds the
// result until the colour stage accepts it.
module mandelbrot_iter_ctrl #(
    parameter int WIDTH      = 8,
    parameter int ITER_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mandelbrot_iter_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [ITER_WIDTH-1:0] iter;
    logic [ITER_WIDTH-1:0] limit;
    logic [WIDTH-1:0]      cr_q, ci_q, zr_q, zi_q;
    logic [ITER_WIDTH-1:0] out_iter_q;
    logic                  out_escaped_q;
    logic                  in_ready_q;
    logic                  out_valid_q;

    // Pixel FSM. The handshake flags are registered alongside the state.
    // Escape takes priority over the limit check, so a point that escapes
    // on its last allowed step still reports as escaped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            iter          <= '0;
            limit         <= '0;
            cr_q          <= '0;
            ci_q          <= '0;
            zr_q          <= '0;
            zi_q          <= '0;
            out_iter_q    <= '0;
            out_escaped_q <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cr_q       <= bus.in_cr;
                        ci_q       <= bus.in_ci;
                        limit      <= bus.max_iter;
                        zr_q       <= '0;
                        zi_q       <= '0;
                        iter       <= '0;
                        in_ready_q <= 1'b0;
                        state      <= ITER;
                    end
                end
                ITER: begin
                    if (bus.alu_size || bus.alu_overflow) begin
                        out_escaped_q <= 1'b1;
                        out_iter_q    <= iter;
                        out_valid_q   <= 1'b1;
                        state         <= DONE;
                    end else if (iter == limit) begin
                        out_escaped_q <= 1'b0;
                        out_iter_q    <= iter;
                        out_valid_q   <= 1'b1;
                        state         <= DONE;
                    end else begin
                        // iter < limit here, so the increment cannot wrap
                        zr_q <= bus.alu_zr_next;
                        zi_q <= bus.alu_zi_next;
                        iter <= iter + 1'b1;
                    end
                end
                DONE: begin
                    // no new point in the handshake cycle; IDLE accepts next
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_iter    = out_iter_q;
    assign bus.out_escaped = out_escaped_q;
    assign bus.alu_cr      = cr_q;
    assign bus.alu_ci      = ci_q;
    assign bus.alu_zr      = zr_q;
    assign bus.alu_zi      = zi_q;

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// Testbench for mandelbrot_iter_ctrl. It stands in for the combinational
// Mandelbrot ALU and keeps a behavioural model of each pixel: the whole
// z trajectory, the final count and the cycle on which the result appears.
// One compare process checks the DUT against this model on every cycle.
module tb_mandelbrot_iter_ctrl;

    localparam int W  = 8;
    localparam int IW = 6;
    localparam int F  = W - 2;
    localparam int HI = (1 << (W - 1)) - 1;
    localparam int LO = -(1 << (W - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mandelbrot_iter_ctrl_if #(.WIDTH(W), .ITER_WIDTH(IW)) bus ();

    mandelbrot_iter_ctrl #(.WIDTH(W), .ITER_WIDTH(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Fixed-point single step z^2 + c in 2.F format. Result bits are
    // {overflow, size, zi_next, zr_next}. Size tests the current z.
    function automatic logic [2*W+1:0] alu_fn(input int zr, input int zi, input int cr, input int ci);
        int a, b, nr, ni;
        logic sz, ov;
        logic [W-1:0] r8, i8;
        a  = zr * zr;
        b  = zi * zi;
        sz = (a + b) > (4 <<< (2 * F));
        nr = ((a - b) >>> F) + cr;
        ni = ((2 * zr * zi) >>> F) + ci;
        ov = (nr > HI) || (nr < LO) || (ni > HI) || (ni < LO);
        r8 = nr[W-1:0];
        i8 = ni[W-1:0];
        return {ov, sz, i8, r8};
    endfunction

    // Combinational ALU environment for the DUT
    assign {bus.alu_overflow, bus.alu_size, bus.alu_zi_next, bus.alu_zr_next} =
        alu_fn($signed(bus.alu_zr), $signed(bus.alu_zi), $signed(bus.alu_cr), $signed(bus.alu_ci));

    // Reference for a whole pixel: iterate until escape or until the limit is reached
    int r_tr [0:63];
    int r_ti [0:63];

    task automatic ref_point(input int cr, input int ci, input int mx, output int n, output bit esc);
        int zr, zi;
        logic [2*W+1:0] r;
        zr = 0; zi = 0; n = 0; esc = 0;
        while (1) begin
            r_tr[n] = zr;
            r_ti[n] = zi;
            r = alu_fn(zr, zi, cr, ci);
            if (r[2*W+1] || r[2*W]) begin esc = 1; break; end
            if (n == mx) break;
            zr = $signed(r[W-1:0]);
            zi = $signed(r[2*W-1:W]);
            n++;
        end
    endtask

    // Model state: one pixel in flight. Its result is due N+1 edges after the handshake edge.
    bit m_busy = 0, m_valid = 0, m_fresh = 1;
    int m_cnt = 0, m_step = 0, m_n = 0;
    bit m_esc = 0;
    int m_cr = 0, m_ci = 0;
    int m_tr [0:63];
    int m_ti [0:63];
    int accepted = 0, aborted = 0, got = 0;

    initial begin
        int n;
        bit e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                if (m_busy || m_valid) aborted++;
                m_busy = 0; m_valid = 0; m_fresh = 1;
            end else begin
                if (bus.out_valid && bus.out_ready) got++;
                if (m_valid) begin
                    if (bus.out_ready) m_valid = 0;
                end else if (m_busy) begin
                    m_cnt--;
                    if (m_cnt == 0) begin m_busy = 0; m_valid = 1; end
                    else m_step++;
                end else if (bus.in_valid) begin
                    m_cr = $signed(bus.in_cr);
                    m_ci = $signed(bus.in_ci);
                    ref_point(m_cr, m_ci, int'(bus.max_iter), n, e);
                    for (int i = 0; i < 64; i++) begin m_tr[i] = r_tr[i]; m_ti[i] = r_ti[i]; end
                    m_n = n; m_esc = e; m_cnt = n + 1; m_step = 0;
                    m_busy = 1; m_fresh = 0;
                    accepted++;
                end
            end
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge
    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", int'(bus.in_ready), int'(!(m_busy || m_valid)));
            chk("out_valid", int'(bus.out_valid), int'(m_valid));
            if (m_valid) begin
                chk("out_iter", int'(bus.out_iter), m_n);
                chk("out_escaped", int'(bus.out_escaped), int'(m_esc));
            end
            if (m_busy || m_valid) begin
                chk("alu_cr", $signed(bus.alu_cr), m_cr);
                chk("alu_ci", $signed(bus.alu_ci), m_ci);
                chk("alu_zr", $signed(bus.alu_zr), m_tr[m_step]);
                chk("alu_zi", $signed(bus.alu_zi), m_ti[m_step]);
            end
            if (m_fresh) begin
                chk("rst_alu", int'({bus.alu_cr, bus.alu_ci, bus.alu_zr, bus.alu_zi} != '0), 0);
                chk("rst_out", int'({bus.out_iter, bus.out_escaped} != '0), 0);
            end
        end
    end

    // Present a point and hold it until the DUT takes it. Returns on the
    // falling edge after the handshake edge.
    task automatic send(input logic [W-1:0] cr, input logic [W-1:0] ci, input int mx);
        int k;
        bus.in_valid = 1'b1;
        bus.in_cr = cr;
        bus.in_ci = ci;
        bus.max_iter = IW'(mx);
        k = 0;
        while (!bus.in_ready && k < 200) begin @(negedge clk); k++; end
        if (k >= 200) chk("send_timeout", k, 0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Wait for out_valid; returns the number of falling edges waited
    task automatic wait_valid(output int e);
        e = 0;
        while (!bus.out_valid && e < 200) begin @(negedge clk); e++; end
        if (e >= 200) chk("valid_timeout", e, 0);
    endtask

    initial begin
        int n, e;
        bit esc;
        bus.in_valid = 0; bus.in_cr = '0; bus.in_ci = '0; bus.max_iter = '0; bus.out_ready = 0;

        // Pin the reference model with hand-computed results
        ref_point(0, 0, 10, n, esc);    chk("pin_c0_n", n, 10); chk("pin_c0_e", int'(esc), 0);
        ref_point(-128, 0, 20, n, esc); chk("pin_m2_n", n, 1);  chk("pin_m2_e", int'(esc), 1);
        ref_point(64, 0, 0, n, esc);    chk("pin_p1_n", n, 0);  chk("pin_p1_e", int'(esc), 0);
        ref_point(64, 0, 20, n, esc);   chk("pin_p1b_n", n, 1); chk("pin_p1b_e", int'(esc), 1);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("reset_in_ready", int'(bus.in_ready), 1);
        chk("reset_out_valid", int'(bus.out_valid), 0);

        // c = 0, limit 10. The handshake cycle is cycle 0; the result is valid in cycle 12.
        bus.out_ready = 1'b1;
        send(8'h00, 8'h00, 10);
        wait_valid(e);
        chk("lat_c0", e + 1, 12);
        chk("c0_iter", int'(bus.out_iter), 10);
        chk("c0_esc", int'(bus.out_escaped), 0);
        @(negedge clk);

        // c = -2.0 escapes by overflow at iteration 1. Hold the result against in_valid.
        bus.out_ready = 1'b0;
        send(8'h80, 8'h00, 20);
        wait_valid(e);
        bus.in_valid = 1'b1; bus.in_cr = 8'h11; bus.in_ci = 8'h22;
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_iter", int'(bus.out_iter), 1);
            chk("hold_esc", int'(bus.out_escaped), 1);
            chk("hold_in_ready", int'(bus.in_ready), 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("release_in_ready", int'(bus.in_ready), 1);
        chk("release_out_valid", int'(bus.out_valid), 0);

        // max_iter = 0: a single ITER cycle, and z is never updated
        send(8'h40, 8'h00, 0);
        wait_valid(e);
        chk("mx0_lat", e + 1, 2);
        chk("mx0_iter", int'(bus.out_iter), 0);
        chk("mx0_esc", int'(bus.out_escaped), 0);
        chk("mx0_zr", int'(bus.alu_zr), 0);
        @(negedge clk);

        // Reset in the middle of ITER aborts the pixel
        send(8'h00, 8'h00, 10);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_alu", int'({bus.alu_cr, bus.alu_ci, bus.alu_zr, bus.alu_zi} != '0), 0);
        chk("abort_in_ready", int'(bus.in_ready), 1);
        e = 0;
        repeat (15) begin @(negedge clk); if (bus.out_valid) e++; end
        chk("abort_no_valid", e, 0);
        send(8'hF0, 8'h10, 5);
        wait_valid(e);
        @(negedge clk);

        // Random traffic: inputs keep changing outside IDLE, and out_ready toggles
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            bus.in_valid = ($urandom % 4) != 0;
            if ($urandom % 2) begin
                bus.in_cr = W'($urandom_range(0, 63) - 32);
                bus.in_ci = W'($urandom_range(0, 63) - 32);
            end else begin
                bus.in_cr = W'($urandom);
                bus.in_ci = W'($urandom);
            end
            bus.max_iter = ($urandom % 3 == 0) ? IW'($urandom) : IW'($urandom % 8);
            bus.out_ready = ($urandom % 3) != 0;
        end

        // Drain the pixel still in flight
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        e = 0;
        while ((m_busy || m_valid) && e < 200) begin @(negedge clk); e++; end
        if (e >= 200) chk("drain_timeout", e, 0);
        repeat (2) @(negedge clk);
        chk("results_count", got, accepted - aborted);
        chk("enough_traffic", int'(accepted > 100), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mandelbrot_iter_ctrl.md
Name: mandelbrot_iter_ctrl

Overview:
Sequencer that drives the combinational Mandelbrot single-step ALU for one pixel at a time.
- Accepts a point c = (cr, ci) over a valid/ready input.
- Presents the current z and c to the ALU, feeds the ALU result back into z each cycle, and counts iterations.
- Stops on escape (size or overflow) or on reaching the iteration limit.
- Returns the iteration count over a valid/ready output to the pixel/colour stage.

Parameters:
WIDTH, 8, word width of c and z; signed fixed point 2.(WIDTH-2), matching the ALU
ITER_WIDTH, 6, width of iteration counter and max_iter

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  point available
in_ready  output  1  controller can accept a point
in_cr  input  WIDTH  real part of c
in_ci  input  WIDTH  imaginary part of c
max_iter  input  ITER_WIDTH  iteration limit, sampled on input handshake
alu_cr  output  WIDTH  c real to ALU (registered)
alu_ci  output  WIDTH  c imag to ALU (registered)
alu_zr  output  WIDTH  current z real to ALU (registered)
alu_zi  output  WIDTH  current z imag to ALU (registered)
alu_zr_next  input  WIDTH  ALU result z real
alu_zi_next  input  WIDTH  ALU result z imag
alu_size  input  1  ALU: current |z|^2 > 4
alu_overflow  input  1  ALU: next z out of range
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_iter  output  ITER_WIDTH  iterations completed
out_escaped  output  1  1 = point escaped, 0 = limit reached

Behaviour:
- Reset (synchronous, active when rst_n=0 at clk rising edge):
  - State goes to IDLE.
  - All registers clear to 0: alu_cr/ci/zr/zi, iteration counter, latched limit, out_iter, out_escaped.
  - out_valid=0 and in_ready=1 from the cycle after reset.
- Reset asserted in any state, including mid-ITER or while out_valid is held, aborts the current pixel. No result is emitted.
- States are IDLE, ITER, DONE.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid&&in_ready: latch alu_cr<=in_cr, alu_ci<=in_ci, limit<=max_iter; clear alu_zr, alu_zi, iter to 0; go to ITER.
- ITER (one ALU step per cycle; the ALU is combinational on the registered outputs):
  - in_ready=0 and out_valid=0.
  - Priority 1: if alu_size|alu_overflow, then out_escaped<=1, out_iter<=iter, go to DONE.
  - Priority 2: else if iter==limit, then out_escaped<=0, out_iter<=iter, go to DONE.
  - Priority 3: else alu_zr<=alu_zr_next, alu_zi<=alu_zi_next, iter<=iter+1, stay in ITER.
  - The counter never wraps: it stops at limit, which is at most 2^ITER_WIDTH-1.
- DONE:
  - out_valid=1; out_iter and out_escaped are held stable until the handshake.
  - in_ready=0.
  - On out_ready: go to IDLE (out_valid=0 next cycle).
  - No new point is accepted in the handshake cycle, so minimum pixel spacing = 1 (IDLE) + cycles in ITER + 1 (DONE).
- Latency: a point that ends at iteration count N reaches out_valid N+2 cycles after the input handshake cycle (N+1 ITER cycles, then DONE).
- max_iter=0: one ITER cycle. With z=0, size=0; overflow is 0 for any representable c. Result is out_iter=0, out_escaped=0.
- max_iter and in_cr/in_ci changing while not in IDLE have no effect.
- out_ready asserted outside DONE is ignored.

Test Plan:
1. WIDTH=8, c=(0x00,0x00), max_iter=10 -> no escape; out_valid exactly 12 cycles after the handshake cycle; out_iter=10, out_escaped=0; in_ready=0 throughout.
2. c=(0x80 = -2.0, 0x00), max_iter=20 -> ITER 0: next z=-2.0. ITER 1: size=0 (|z|^2=4 is not >4) and overflow=1 (next zr=2.0). Result out_iter=1, out_escaped=1.
3. c=(0x40 = 1.0, 0x00), max_iter=0 -> out_iter=0, out_escaped=0 after one ITER cycle; alu_zr remains 0x00.
4. Result from scenario 2 with out_ready held 0 for 5 cycles -> out_valid, out_iter=1, out_escaped=1 stable for all 5 cycles; in_ready=0 and in_valid ignored. out_ready=1 -> IDLE next cycle with in_ready=1.
5. Scenario 1 with rst_n=0 for one cycle at ITER cycle 4 -> next cycle IDLE; all alu_* outputs 0; out_valid never asserts; a new point is accepted normally afterwards.
6. Back-to-back points with in_valid held high and out_ready=1 -> each point is accepted only in IDLE; results appear in order with correct counts; no point is dropped or duplicated.
